// File: rtl/ofdm_pkg.sv
// Shared OFDM constellation constants and sample packing, used by the TX mapper and RX demapper.
package ofdm_pkg;

    localparam int LEVEL_HI = 32736;
    localparam int LEVEL_LO = 10803;
    localparam int THRESH   = 21770;

    typedef enum logic [1:0] {
        AxisNegHi = 2'b00,
        AxisNegLo = 2'b01,
        AxisPosHi = 2'b10,
        AxisPosLo = 2'b11
    } axis_code_e;

    // One FFT bin as carried on the 32-bit stream: {re, im}.
    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } iq_t;

endpackage

// File: rtl/qam_demapper_if.sv
// Valid/ready stream with frame-last marker; used for both the sample input and word output.
interface qam_demapper_if #(
    parameter int unsigned W = 32
) ();
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    logic         last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/qam_axis_slicer.sv
// Hard decision of one signed axis onto the four 16-QAM amplitude levels.
module qam_axis_slicer
    import ofdm_pkg::*;
(
    input  logic signed [15:0] x_i,
    output axis_code_e         code_o
);

    localparam logic signed [15:0] Th = 16'(THRESH);

    always_comb begin
        if (x_i >= Th) begin
            code_o = AxisPosHi;
        end else if (x_i >= 16'sd0) begin
            code_o = AxisPosLo;
        end else if (x_i > -Th) begin
            code_o = AxisNegLo;
        end else begin
            code_o = AxisNegHi;
        end
    end

endmodule

// File: rtl/qam_demapper.sv
// RX 16-QAM demapper: slices enabled data bins of each FFT frame and packs symbols MSB-first.
module qam_demapper
    import ofdm_pkg::*;
#(
    parameter int unsigned B     = 8,
    parameter int unsigned N     = 8,
    parameter int unsigned M     = 16,
    parameter int unsigned LOG2M = 4
) (
    input  logic          aclk,
    input  logic          reset,
    input  logic [N-1:0]  carrier_control,
    qam_demapper_if.slave  s_axis,
    qam_demapper_if.master m_axis,
    output logic          frame_done,
    output logic          frame_err
);

    localparam int unsigned BinW = $clog2(2 * N);
    localparam int unsigned IdxW = $clog2(N);
    localparam int unsigned SymW = $clog2(M);
    localparam int unsigned CntW = $clog2(2 * B + 1);

    logic [BinW-1:0] bin_cnt_q, bin_cnt_d;
    logic [N-1:0]    ctl_q, ctl_d, ctl_eff;
    logic            v1_q, v1_d, act_q, act_d, last_q, last_d, done_q, done_d;
    logic [SymW-1:0] sym_q, sym_d;
    logic [2*B-1:0]  acc_q, acc_d, shifted;
    logic [CntW-1:0] acc_cnt_q, acc_cnt_d;
    logic [B-1:0]    data_q, data_d;
    logic            m_valid_q, m_valid_d, frame_err_q, frame_err_d;
    logic            adv2, s_ready, beat, retire, end_bin, active;
    iq_t             iq;
    axis_code_e      code_re, code_im;

    assign iq = iq_t'(s_axis.data);

    qam_axis_slicer u_slice_re (.x_i(iq.re), .code_o(code_re));
    qam_axis_slicer u_slice_im (.x_i(iq.im), .code_o(code_im));

    always_comb begin
        adv2    = !m_valid_q || m_axis.ready;
        s_ready = !v1_q || adv2;
        beat    = s_axis.valid && s_ready;
        retire  = v1_q && adv2;
        end_bin = (bin_cnt_q == BinW'(2 * N - 1));
        // The mask for the current frame is latched on bin 0, so bin 0 sees the live input.
        ctl_eff = (bin_cnt_q == '0) ? carrier_control : ctl_q;
        active  = (bin_cnt_q != '0) && (bin_cnt_q < BinW'(N)) && ctl_eff[bin_cnt_q[IdxW-1:0]];
    end

    always_comb begin
        bin_cnt_d   = bin_cnt_q;
        ctl_d       = ctl_q;
        frame_err_d = 1'b0;
        v1_d        = v1_q;
        sym_d       = sym_q;
        act_d       = act_q;
        last_d      = last_q;
        done_d      = done_q;
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        data_d      = data_q;
        m_valid_d   = m_valid_q && !m_axis.ready;
        shifted     = '0;
        frame_done  = retire && done_q;

        if (beat) begin
            if (bin_cnt_q == '0) begin
                ctl_d = carrier_control;
            end
            bin_cnt_d   = (end_bin || s_axis.last) ? '0 : bin_cnt_q + 1'b1;
            frame_err_d = end_bin != s_axis.last;
        end

        if (s_ready) begin
            v1_d   = beat;
            sym_d  = {code_re, code_im};
            act_d  = active;
            last_d = end_bin || s_axis.last;
            done_d = end_bin;
        end

        if (retire && act_q) begin
            acc_d     = {acc_q[2*B-SymW-1:0], sym_q};
            acc_cnt_d = acc_cnt_q + CntW'(LOG2M);
            if (acc_cnt_d >= CntW'(B)) begin
                shifted   = acc_d >> (acc_cnt_d - CntW'(B));
                data_d    = shifted[B-1:0];
                m_valid_d = 1'b1;
                acc_cnt_d = acc_cnt_d - CntW'(B);
            end
        end

        // A word completed by the final symbol is still emitted; only the partial tail is dropped.
        if (retire && last_q) begin
            acc_cnt_d = '0;
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            bin_cnt_q   <= '0;
            ctl_q       <= '0;
            frame_err_q <= 1'b0;
            v1_q        <= 1'b0;
            sym_q       <= '0;
            act_q       <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            data_q      <= '0;
            m_valid_q   <= 1'b0;
        end else begin
            bin_cnt_q   <= bin_cnt_d;
            ctl_q       <= ctl_d;
            frame_err_q <= frame_err_d;
            v1_q        <= v1_d;
            sym_q       <= sym_d;
            act_q       <= act_d;
            last_q      <= last_d;
            done_q      <= done_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            data_q      <= data_d;
            m_valid_q   <= m_valid_d;
        end
    end

    assign s_axis.ready = s_ready;
    assign m_axis.data  = data_q;
    assign m_axis.valid = m_valid_q;
    assign m_axis.last  = 1'b0;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_qam_demapper.sv
// Randomised bench for qam_demapper with a bit-queue reference model and directed literal cases.
module tb_qam_demapper;
    import ofdm_pkg::*;

    logic       aclk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] carrier_control = 8'hFE;
    logic       frame_done, frame_err;

    qam_demapper_if #(.W(32)) s_if ();
    qam_demapper_if #(.W(8))  m_if ();

    qam_demapper #(.B(8), .N(8), .M(16), .LOG2M(4)) dut (
        .aclk            (aclk),
        .reset           (reset),
        .carrier_control (carrier_control),
        .s_axis          (s_if),
        .m_axis          (m_if),
        .frame_done      (frame_done),
        .frame_err       (frame_err)
    );

    always #5 aclk = ~aclk;

    int          errors = 0, checks = 0;
    bit          gaps = 0, rand_ready = 0;
    int          cyc = 0, stall_until = 0;
    logic [31:0] frame_buf [16];
    logic [7:0]  exp_q[$], got_q[$];
    bit          pend[$];
    int          m_bin = 0;
    logic [7:0]  m_mask = 8'h00;
    bit          err_pending = 0, prev_hold = 0, saw_sready_low = 0;
    logic [7:0]  prev_data = 8'h00;
    int          exp_done = 0, obs_done = 0, obs_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [1:0] slice(input int x);
        if (x >= 21770) return 2'b10;
        if (x >= 0) return 2'b11;
        if (x > -21770) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [15:0] lvl(input logic [1:0] c);
        case (c)
            2'b10:   return 16'(32736);
            2'b11:   return 16'(10803);
            2'b01:   return 16'(-10803);
            default: return 16'(-32736);
        endcase
    endfunction

    function automatic logic [31:0] pt(input logic [3:0] s);
        return {lvl(s[3:2]), lvl(s[1:0])};
    endfunction

    function automatic logic [7:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 8'hxx;
    endfunction

    // Reference: slice enabled bins, push bits MSB-first, emit every full byte, drop tail at frame end.
    task automatic model_beat(input logic [31:0] d, input logic l);
        logic [1:0] c;
        logic [7:0] w;
        if (m_bin == 0) m_mask = carrier_control;
        if (m_bin >= 1 && m_bin <= 7 && m_mask[m_bin]) begin
            c = slice(int'($signed(d[31:16])));
            pend.push_back(c[1]); pend.push_back(c[0]);
            c = slice(int'($signed(d[15:0])));
            pend.push_back(c[1]); pend.push_back(c[0]);
            while (pend.size() >= 8) begin
                w = 8'h00;
                repeat (8) w = {w[6:0], pend.pop_front()};
                exp_q.push_back(w);
            end
        end
        err_pending = (l && m_bin != 15) || (m_bin == 15 && !l);
        if (m_bin == 15) exp_done++;
        if (l || m_bin == 15) begin
            pend.delete();
            m_bin = 0;
        end else begin
            m_bin++;
        end
    endtask

    initial begin
        m_if.ready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            cyc++;
            if (cyc < stall_until) m_if.ready = 1'b0;
            else if (rand_ready) m_if.ready = ($urandom_range(0, 3) != 0);
            else m_if.ready = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge aclk);
            if (reset) begin
                exp_q.delete();
                pend.delete();
                m_bin = 0;
                err_pending = 0;
                prev_hold = 0;
            end else begin
                check("frame_err", frame_err, err_pending);
                if (frame_err) obs_err++;
                if (frame_done) obs_done++;
                if (prev_hold) begin
                    check("hold_valid", m_if.valid, 1);
                    check("hold_data", m_if.data, prev_data);
                end
                if (m_if.valid && m_if.ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL word: got %02h expected none", m_if.data);
                    end else begin
                        check("word", m_if.data, exp_q.pop_front());
                    end
                    got_q.push_back(m_if.data);
                end
                prev_hold = m_if.valid && !m_if.ready;
                prev_data = m_if.data;
                if (!s_if.ready) saw_sready_low = 1;
                err_pending = 0;
                if (s_if.valid && s_if.ready) model_beat(s_if.data, s_if.last);
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic l);
        bit ok;
        int n;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
        s_if.valid = 1'b1;
        s_if.data  = d;
        s_if.last  = l;
        n = 0;
        do begin
            @(negedge aclk);
            ok = s_if.ready;
            @(posedge aclk); #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) check("beat_timeout", 0, 1);
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
    endtask

    task automatic send_frame(input int len, input int dlast_bin);
        for (int i = 0; i < len; i++) send_beat(frame_buf[i], i == dlast_bin);
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 16; i++) frame_buf[i] = $urandom;
    endtask

    task automatic drain(input int n);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int err0;
        int dl;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        s_if.last  = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_sready", s_if.ready, 1);
        check("rst_mvalid", m_if.valid, 0);
        check("rst_mdata", m_if.data, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", frame_err, 0);
        @(posedge aclk); #1;
        reset = 1'b0;
        drain(2);

        // Ideal constellation points
        rand_frame();
        frame_buf[0] = 32'h0;
        frame_buf[1] = pt(4'hA); frame_buf[2] = pt(4'h5); frame_buf[3] = pt(4'h3);
        frame_buf[4] = pt(4'hC); frame_buf[5] = pt(4'hF); frame_buf[6] = pt(4'h0);
        frame_buf[7] = pt(4'h6);
        carrier_control = 8'hFE;
        got_q.delete();
        send_frame(16, 15);
        drain(10);
        check("t1_count", got_q.size(), 3);
        check("t1_w0", got_at(0), 8'hA5);
        check("t1_w1", got_at(1), 8'h3C);
        check("t1_w2", got_at(2), 8'hF0);
        check("t1_done", obs_done, 1);

        // Slicer thresholds on both axes
        rand_frame();
        frame_buf[1] = {16'(21770), 16'(21770)};
        frame_buf[2] = {16'(21769), 16'(21769)};
        frame_buf[3] = 32'h0;
        frame_buf[4] = {16'(-1), 16'(-1)};
        frame_buf[5] = {16'(-21769), 16'(-21769)};
        frame_buf[6] = {16'(-21770), 16'(-21770)};
        frame_buf[7] = 32'h0;
        got_q.delete();
        send_frame(16, 15);
        drain(10);
        check("t2_count", got_q.size(), 3);
        check("t2_w0", got_at(0), 8'hAF);
        check("t2_w1", got_at(1), 8'hF5);
        check("t2_w2", got_at(2), 8'h50);

        // Noisy sample
        rand_frame();
        frame_buf[1] = {16'(15000), 16'(-25000)};
        frame_buf[2] = 32'h7FE0_7FE0;
        carrier_control = 8'h06;
        got_q.delete();
        send_frame(16, 15);
        drain(10);
        check("t3_count", got_q.size(), 1);
        check("t3_w0", got_at(0), 8'hCA);

        // Sparse mask, mask change mid-frame ignored
        rand_frame();
        frame_buf[1] = pt(4'h3);
        frame_buf[3] = pt(4'h9);
        carrier_control = 8'h0A;
        got_q.delete();
        fork
            send_frame(16, 15);
            begin drain(4); carrier_control = 8'hFF; end
        join
        drain(10);
        check("t4_count", got_q.size(), 1);
        check("t4_w0", got_at(0), 8'h39);

        // Backpressure mid-frame
        rand_frame();
        carrier_control = 8'hFF;
        saw_sready_low = 0;
        got_q.delete();
        fork
            send_frame(16, 15);
            begin drain(4); stall_until = cyc + 10; end
        join
        drain(10);
        check("t5_sready_low", saw_sready_low, 1);
        check("t5_count", got_q.size(), 3);

        // Early s_dlast, then missing s_dlast
        carrier_control = 8'hFE;
        err0 = obs_err;
        rand_frame();
        frame_buf[1] = pt(4'h8); frame_buf[2] = pt(4'h9); frame_buf[3] = pt(4'hA);
        frame_buf[4] = pt(4'hB); frame_buf[5] = pt(4'hC);
        got_q.delete();
        send_frame(6, 5);
        rand_frame();
        for (int i = 1; i <= 7; i++) frame_buf[i] = pt(4'(i));
        send_frame(16, 15);
        drain(10);
        check("t6_count", got_q.size(), 5);
        check("t6_w0", got_at(0), 8'h89);
        check("t6_w1", got_at(1), 8'hAB);
        check("t6_w2", got_at(2), 8'h12);
        check("t6_w3", got_at(3), 8'h34);
        check("t6_w4", got_at(4), 8'h56);
        check("t6_err_early", obs_err - err0, 1);
        rand_frame();
        send_frame(16, -1);
        drain(10);
        check("t6_err_nolast", obs_err - err0, 2);

        // Reset mid-frame with a word held at the output
        rand_frame();
        carrier_control = 8'hFF;
        stall_until = cyc + 40;
        send_frame(3, -1);
        drain(3);
        check("pre_rst_valid", m_if.valid, 1);
        reset = 1'b1;
        @(negedge aclk);
        check("mid_rst_sready", s_if.ready, 1);
        check("mid_rst_mvalid", m_if.valid, 0);
        check("mid_rst_mdata", m_if.data, 0);
        check("mid_rst_done", frame_done, 0);
        check("mid_rst_err", frame_err, 0);
        @(posedge aclk); #1;
        reset = 1'b0;
        stall_until = 0;
        drain(2);
        rand_frame();
        send_frame(16, 15);
        drain(10);

        // Randomised traffic
        rand_ready = 1;
        gaps = 1;
        for (int f = 0; f < 12; f++) begin
            rand_frame();
            carrier_control = 8'($urandom);
            dl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : 15;
            send_frame(dl + 1, dl);
        end
        rand_ready = 0;
        drain(20);
        check("end_queue_empty", exp_q.size(), 0);
        check("end_done_count", obs_done, exp_done);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
